// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the ROM and buffers fetched
// {pc, instr} pairs in a small FIFO presented to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ROM_BYTES = 800,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [31:0] o_rom_addr,
  input  logic [31:0] i_rom_data,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  output logic        o_fault
);

  localparam int unsigned PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam logic [31:0] LAST_PC = 32'(ROM_BYTES - 4);

  logic [31:0]      pc_q, pc_d;
  logic             fault_q, fault_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      mem_pc_q    [DEPTH];
  logic [31:0]      mem_instr_q [DEPTH];

  logic pop, push, in_range;

  // Next-state: redirect overrides everything and flushes the FIFO.
  always_comb begin
    pc_d     = pc_q;
    fault_d  = fault_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    in_range = (pc_q <= LAST_PC);
    pop      = (count_q != '0) & i_ready;
    push     = ~fault_q & ~i_redirect & in_range & ((count_q < CNT_W'(DEPTH)) | pop);

    if (i_redirect) begin
      pc_d     = i_redirect_pc;
      fault_d  = (i_redirect_pc[1:0] != 2'b00) | (i_redirect_pc > LAST_PC);
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (!in_range) begin
        fault_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q     <= RESET_PC;
      fault_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      fault_q  <= fault_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]    <= pc_q;
      mem_instr_q[wr_ptr_q] <= i_rom_data;
    end
  end

  assign o_rom_addr = pc_q;
  assign o_valid    = (count_q != '0);
  assign o_instr    = o_valid ? mem_instr_q[rd_ptr_q] : 32'h0;
  assign o_instr_pc = o_valid ? mem_pc_q[rd_ptr_q] : 32'h0;
  assign o_fault    = fault_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction ROM and downstream of it at the same time. It owns the program counter, drives the ROM byte address, and captures the returned 32-bit big-endian word together with its PC into a small FIFO. The FIFO presents instructions to decode over a valid/ready handshake. It supports branch redirect with flush and flags out-of-range or misaligned fetches.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be word-aligned.
- ROM_BYTES, 800, size of the instruction ROM in bytes; last fetchable address is ROM_BYTES-4.
- DEPTH, 2, FIFO entries; power of two, ≥2.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- o_rom_addr  out  32  byte address to ROM; equals the PC register (combinational from the register, no logic on input ports).
- i_rom_data  in  32  ROM word at o_rom_addr; combinational, valid in the same cycle.
- i_redirect  in  1  load new PC and flush; single-cycle pulse or level.
- i_redirect_pc  in  32  target PC, sampled when i_redirect=1.
- o_valid  out  1  FIFO head holds an instruction.
- i_ready  in  1  decode accepts head this cycle.
- o_instr  out  32  instruction at FIFO head; 0 when empty.
- o_instr_pc  out  32  PC of o_instr; 0 when empty.
- o_fault  out  1  sticky fetch fault.

## Operation
- State: pc[31:0], FIFO storage {pc, instr} × DEPTH, wr_ptr, rd_ptr, count (0..DEPTH), fault.
- pop = o_valid & i_ready.
- can_fetch = !fault & !i_redirect & (pc <= ROM_BYTES-4) & (count < DEPTH | pop).
- push = can_fetch: write {pc, i_rom_data} at wr_ptr; pc <= pc + 4 (32-bit, wrap irrelevant due to range check).
- Simultaneous push and pop on full FIFO allowed; count unchanged.
- Redirect (highest priority): count, wr_ptr, rd_ptr <= 0; no push that cycle. A pop in the same cycle still completes on the handshake, but the entry is flushed anyway.
  - If i_redirect_pc[1:0]==0 and i_redirect_pc <= ROM_BYTES-4: pc <= i_redirect_pc, fault <= 0.
  - Otherwise pc <= i_redirect_pc and fault <= 1.
- Running off the end: when pc reaches a value > ROM_BYTES-4 with no redirect, fault <= 1 on the next edge. Fetch stops; existing FIFO entries still drain.
- While fault=1, no pushes; only a legal redirect or reset clears it.
- o_valid = (count != 0). o_instr / o_instr_pc read the entry at rd_ptr when valid, and are forced to 0 otherwise.
- Reset: pc=RESET_PC, pointers=0, count=0, fault=0. Hence o_rom_addr=RESET_PC, o_valid=0, o_instr=0, o_instr_pc=0, o_fault=0.

## Timing
- Fetch latency: address presented cycle N; instruction on o_instr with o_valid=1 in cycle N+1 if FIFO was empty.
- Throughput: one instruction per cycle with i_ready held high; no bubbles.
- Stall: i_ready=0 lets the FIFO fill to DEPTH; then pc holds and o_rom_addr is stable. When i_ready rises, fetch resumes in the same cycle (push with pop).
- Redirect asserted in cycle N: o_valid=0 and o_rom_addr=target in N+1; first target instruction valid in N+2.
- Reset asserted mid-operation clears all state immediately (asynchronous), without waiting for a clock edge. The first fetch after deassertion occurs on the first rising edge with i_rst=0.
- o_fault rises one edge after the offending redirect or pc overrun.

## Test plan
- Reset release, ROM word k = 32'h1000_0000+k, i_ready=1: o_valid rises 1 cycle after reset; outputs (pc,instr) = (0,10000000),(4,10000001),(8,10000002)… one per cycle.
- i_ready=0 for 5 cycles after first instr: count saturates at 2; o_rom_addr frozen at 8; after release sequence resumes PC 0,4,8,12 with no loss or duplicate.
- Redirect to 0x40 while FIFO full: next cycle o_valid=0, o_rom_addr=0x40; cycle after o_instr=1000_0010, o_instr_pc=0x40.
- Sequential run to end with ROM_BYTES=16: instrs PC 0..12 delivered, then o_fault=1, o_rom_addr=16, no further pushes; redirect to 0 clears fault and refetches PC 0.
- Redirect to 0x42 (misaligned) → o_fault=1 next cycle, o_valid=0 from next cycle; then redirect to 0x8 → fault=0, PC 8 delivered.
- Assert i_rst asynchronously between edges while FIFO holds 2 entries: o_valid, o_fault, o_instr drop to 0 immediately; o_rom_addr=RESET_PC.
